// File: rtl/retire_trace_pkg.sv
// Shared types for the retirement trace unit.
// RETIRE_TRACE_STORE_EN adds store address/data to each record.
package retire_trace_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } stage_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
`ifdef RETIRE_TRACE_STORE_EN
    logic        st;
    logic [31:0] st_addr;
    logic [31:0] st_data;
`endif
  } trace_rec_t;

  localparam stage_t BUBBLE = '{
    valid: 1'b0,
    pc:    32'h0,
    instr: NOP_INSTR
  };

  // Writes to x0 are architecturally invisible.
  function automatic logic rd_write(
    input logic       we,
    input logic [4:0] rd
  );
    return we && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record buffer for retire_trace; read data is zero while empty.
// Simultaneous push and pop is accepted even when full.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign full  = (r_cnt == FULL_CNT);
  assign empty = (r_cnt == '0);
  assign w_rd  = pop & ~empty;
  assign w_wr  = push & (~full | w_rd);
  assign rdata = empty ? '0 : r_mem[r_rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= wdata;
  end

endmodule

// File: rtl/retire_trace.sv
// Shadow 5-stage pipeline that emits one trace record per retired instruction.
// RETIRE_TRACE_STORE_EN adds mem_* inputs and trc_st* outputs.
module retire_trace
  import retire_trace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
`ifdef RETIRE_TRACE_STORE_EN
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  output logic             trc_st,
  output logic [31:0]      trc_st_addr,
  output logic [31:0]      trc_st_data,
`endif
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [31:0]      trc_pc,
  output logic [31:0]      trc_instr,
  output logic [31:0]      trc_data,
  output logic [4:0]       trc_rd,
  output logic             trc_we,
  output logic [SEQ_W-1:0] trc_seq,
  output logic             overflow
);

  localparam int RW = $bits(trace_rec_t) + SEQ_W;

  stage_t           r_ifid;
  stage_t           r_idex;
  stage_t           r_exmem;
  stage_t           r_memwb;
  logic [SEQ_W-1:0] r_seq;
  logic             r_ovf;

  logic             w_retire;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  stage_t           w_fetch;
  trace_rec_t       w_rec;
  trace_rec_t       w_out;
  logic [SEQ_W-1:0] w_out_seq;
  logic [RW-1:0]    w_wdata;
  logic [RW-1:0]    w_rdata;

`ifdef RETIRE_TRACE_STORE_EN
  logic             r_st;
  logic [31:0]      r_st_addr;
  logic [31:0]      r_st_data;
`endif

  assign w_fetch = '{valid: if_valid, pc: if_pc, instr: if_instr};

  assign w_retire = r_memwb.valid & ~stall;
  assign w_pop    = trc_valid & trc_ready;
  assign w_drop   = w_retire & w_full & ~w_pop;
  assign w_push   = w_retire & ~w_drop;

  // Flush kills whatever sits in IF/ID and ID/EX, so EX/MEM takes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid  <= BUBBLE;
      r_idex  <= BUBBLE;
      r_exmem <= BUBBLE;
      r_memwb <= BUBBLE;
      r_seq   <= '0;
    end else if (!stall) begin
      r_ifid        <= flush ? BUBBLE : w_fetch;
      r_idex        <= flush ? BUBBLE : r_ifid;
      r_exmem       <= r_idex;
      r_exmem.valid <= r_idex.valid & ~flush;
      r_memwb       <= r_exmem;
      if (w_retire) r_seq <= r_seq + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

`ifdef RETIRE_TRACE_STORE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st      <= 1'b0;
      r_st_addr <= '0;
      r_st_data <= '0;
    end else if (!stall) begin
      r_st      <= mem_we & r_exmem.valid;
      r_st_addr <= mem_addr;
      r_st_data <= mem_wdata;
    end
  end
`endif

  always_comb begin
    w_rec       = '0;
    w_rec.pc    = r_memwb.pc;
    w_rec.instr = r_memwb.instr;
    w_rec.rd    = wb_rd;
    w_rec.data  = wb_data;
    w_rec.we    = rd_write(wb_we, wb_rd);
`ifdef RETIRE_TRACE_STORE_EN
    w_rec.st      = r_st;
    w_rec.st_addr = r_st_addr;
    w_rec.st_data = r_st_data;
`endif
  end

  assign w_wdata = {w_rec, r_seq};

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  assign {w_out, w_out_seq} = w_rdata;

  assign trc_valid = ~w_empty;
  assign trc_pc    = w_out.pc;
  assign trc_instr = w_out.instr;
  assign trc_data  = w_out.data;
  assign trc_rd    = w_out.rd;
  assign trc_we    = w_out.we;
  assign trc_seq   = w_out_seq;
  assign overflow  = r_ovf;

`ifdef RETIRE_TRACE_STORE_EN
  assign trc_st      = w_out.st;
  assign trc_st_addr = w_out.st_addr;
  assign trc_st_data = w_out.st_data;
`endif

endmodule

// File: tb/tb_retire_trace.sv
// Self-checking bench for retire_trace against an instruction-timeline model.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_retire_trace;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00700293;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid, stall, flush, wb_we, trc_ready;
  logic [31:0] if_pc, if_instr, wb_data;
  logic [4:0]  wb_rd;
  logic        trc_valid, trc_we, overflow;
  logic [31:0] trc_pc, trc_instr, trc_data;
  logic [4:0]  trc_rd;
  logic [15:0] trc_seq;
`ifdef RETIRE_TRACE_STORE_EN
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        trc_st;
  logic [31:0] trc_st_addr, trc_st_data;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  retire_trace #(.DEPTH(DEPTH), .SEQ_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef RETIRE_TRACE_STORE_EN
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .trc_st(trc_st), .trc_st_addr(trc_st_addr), .trc_st_data(trc_st_data),
`endif
    .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_pc(trc_pc), .trc_instr(trc_instr), .trc_data(trc_data),
    .trc_rd(trc_rd), .trc_we(trc_we), .trc_seq(trc_seq),
    .overflow(overflow)
  );

  // Model: each in-flight instruction carries how many advancing edges it has
  // seen since fetch; the fourth one retires it.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          age;
  } fl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic [15:0] seq;
  } mrec_t;

  fl_t   pipe[$];
  mrec_t mq[$];
  int    mseq;
  bit    movf;

  function automatic logic [119:0] obs();
    return {trc_valid, trc_pc, trc_instr, trc_rd, trc_data,
            trc_we, trc_seq, overflow};
  endfunction

  function automatic logic [119:0] expv();
    if (mq.size() == 0) return 120'(movf);
    return {1'b1, mq[0], movf};
  endfunction

  task automatic model_reset();
    pipe.delete();
    mq.delete();
    mseq = 0;
    movf = 0;
  endtask

  task automatic model_edge();
    fl_t   np[$];
    fl_t   e;
    mrec_t r;
    bit    have, pop, drop;
    if (rst) begin
      model_reset();
      return;
    end
    have = 0;
    r    = '0;
    pop  = (mq.size() != 0) && trc_ready;
    if (!stall) begin
      foreach (pipe[i]) begin
        if (pipe[i].age == 3) begin
          have    = 1;
          r.pc    = pipe[i].pc;
          r.instr = pipe[i].instr;
          r.rd    = wb_rd;
          r.data  = wb_data;
          r.we    = wb_we && (wb_rd != 0);
          r.seq   = 16'(mseq);
        end else if (!(flush && pipe[i].age <= 1)) begin
          e = pipe[i];
          e.age++;
          np.push_back(e);
        end
      end
      if (!flush && if_valid) begin
        e.pc = if_pc;
        e.instr = if_instr;
        e.age = 0;
        np.push_back(e);
      end
      pipe = np;
      if (have) mseq = (mseq + 1) % 65536;
    end
    drop = have && (mq.size() == DEPTH) && !pop;
    if (drop) movf = 1;
    if (pop) void'(mq.pop_front());
    if (have && !drop) mq.push_back(r);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    if_valid = 0; if_pc = 0; if_instr = NOP;
    stall = 0; flush = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  // WB values the CPU would present for whatever sits in MEM/WB.
  task automatic drive_wb();
    foreach (pipe[i]) begin
      if (pipe[i].age == 3) begin
        wb_we = 1;
        wb_rd = (pipe[i].instr == ADDI) ? 5'd5 : 5'd0;
        wb_data = (pipe[i].instr == ADDI) ? 32'd7 : 32'd0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    model_reset();
    idle();
    trc_ready = 1;
    @(negedge clk);
    n_chk++;
    if (obs() !== '0) begin
      n_err++;
      $display("FAIL reset_state got=%h exp=0", obs());
    end
    tick();
    n_chk++;
    if (obs() !== expv()) begin
      n_err++;
      $display("FAIL reset_hold got=%h exp=%h", obs(), expv());
    end
    rst = 0;
  endtask

  task automatic test_stream();
    int first = -1;
    int npop = 0;
    do_reset();
    trc_ready = 1;
    for (int c = 0; c < 16; c++) begin
      idle();
      if (c < 6) begin if_valid = 1; if_pc = 32'(4 * c); end
      drive_wb();
      tick();
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL stream c%0d got=%h exp=%h", c, obs(), expv());
      end
      if (trc_valid && first < 0) first = c + 1;
      if (trc_valid) begin
        n_chk++;
        if (trc_pc !== 32'(4 * npop) || trc_seq !== 16'(npop)) begin
          n_err++;
          $display("FAIL stream_order pc=%h seq=%0d exp pc=%h seq=%0d",
                   trc_pc, trc_seq, 4 * npop, npop);
        end
        npop++;
      end
    end
    n_chk++;
    if (first != 5) begin
      n_err++;
      $display("FAIL first_latency got=%0d exp=5", first);
    end
    n_chk++;
    if (npop != 6) begin
      n_err++;
      $display("FAIL stream_count got=%0d exp=6", npop);
    end
  endtask

  task automatic test_addi();
    int seen_a = 0;
    int seen_n = 0;
    trc_ready = 1;
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c == 0) begin if_valid = 1; if_pc = 32'h100; if_instr = ADDI; end
      if (c == 1) begin if_valid = 1; if_pc = 32'h104; end
      drive_wb();
      tick();
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL addi c%0d got=%h exp=%h", c, obs(), expv());
      end
      if (trc_valid && trc_pc == 32'h100) begin
        seen_a++;
        n_chk++;
        if ({trc_rd, trc_we, trc_data} !== {5'd5, 1'b1, 32'd7}) begin
          n_err++;
          $display("FAIL addi_fields rd=%0d we=%b data=%h exp 5 1 7",
                   trc_rd, trc_we, trc_data);
        end
      end
      if (trc_valid && trc_pc == 32'h104) begin
        seen_n++;
        n_chk++;
        if (trc_we !== 1'b0) begin
          n_err++;
          $display("FAIL nop_we got=%b exp=0", trc_we);
        end
      end
    end
    n_chk++;
    if (seen_a != 1 || seen_n != 1) begin
      n_err++;
      $display("FAIL addi_seen got=%0d/%0d exp=1/1", seen_a, seen_n);
    end
  endtask

  task automatic test_flush();
    logic [31:0] gpc[$];
    logic [15:0] gseq[$];
    logic [31:0] want[5];
    want = '{32'h0, 32'h4, 32'h40, 32'h44, 32'h48};
    do_reset();
    trc_ready = 1;
    for (int c = 0; c < 18; c++) begin
      idle();
      if (c < 4) begin if_valid = 1; if_pc = 32'(4 * c); end
      if (c == 4) begin if_valid = 1; if_pc = 32'h10; flush = 1; end
      if (c >= 5 && c <= 7) begin
        if_valid = 1;
        if_pc = 32'h40 + 32'(4 * (c - 5));
      end
      drive_wb();
      tick();
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL flush c%0d got=%h exp=%h", c, obs(), expv());
      end
      if (trc_valid) begin gpc.push_back(trc_pc); gseq.push_back(trc_seq); end
    end
    n_chk++;
    if (gpc.size() != 5) begin
      n_err++;
      $display("FAIL flush_count got=%0d exp=5", gpc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (gpc[i] !== want[i] || gseq[i] !== 16'(i)) begin
          n_err++;
          $display("FAIL flush_rec%0d pc=%h seq=%0d exp pc=%h seq=%0d",
                   i, gpc[i], gseq[i], want[i], i);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] gpc[$];
    logic [15:0] gseq[$];
    int k = 0;
    do_reset();
    trc_ready = 1;
    for (int c = 0; c < 20; c++) begin
      idle();
      if (k < 8) begin if_valid = 1; if_pc = 32'h300 + 32'(4 * k); end
      stall = (c >= 4 && c <= 6);
      drive_wb();
      if (!stall && if_valid) k++;
      tick();
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL stall c%0d got=%h exp=%h", c, obs(), expv());
      end
      if (trc_valid) begin gpc.push_back(trc_pc); gseq.push_back(trc_seq); end
    end
    n_chk++;
    if (gpc.size() != 8) begin
      n_err++;
      $display("FAIL stall_count got=%0d exp=8", gpc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (gpc[i] !== 32'h300 + 32'(4 * i) || gseq[i] !== 16'(i)) begin
          n_err++;
          $display("FAIL stall_rec%0d pc=%h seq=%0d", i, gpc[i], gseq[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] gseq[$];
    do_reset();
    trc_ready = 0;
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c < DEPTH + 1) begin if_valid = 1; if_pc = 32'h500 + 32'(4 * c); end
      drive_wb();
      tick();
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL ovf_fill c%0d got=%h exp=%h", c, obs(), expv());
      end
    end
    n_chk++;
    if ({overflow, trc_valid, trc_seq} !== {1'b1, 1'b1, 16'd0}) begin
      n_err++;
      $display("FAIL ovf_flag ovf=%b valid=%b seq=%0d exp 1 1 0",
               overflow, trc_valid, trc_seq);
    end
    trc_ready = 1;
    for (int c = 0; c < 6; c++) begin
      idle();
      if (trc_valid) gseq.push_back(trc_seq);
      tick();
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL ovf_drain c%0d got=%h exp=%h", c, obs(), expv());
      end
    end
    n_chk++;
    if (gseq.size() != DEPTH) begin
      n_err++;
      $display("FAIL ovf_held got=%0d exp=%0d", gseq.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_chk++;
        if (gseq[i] !== 16'(i)) begin
          n_err++;
          $display("FAIL ovf_seq%0d got=%0d exp=%0d", i, gseq[i], i);
        end
      end
    end
    gseq.delete();
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0) begin if_valid = 1; if_pc = 32'h600; end
      drive_wb();
      if (trc_valid) gseq.push_back(trc_seq);
      tick();
    end
    n_chk++;
    if (gseq.size() != 1 || gseq[0] !== 16'd5) begin
      n_err++;
      $display("FAIL ovf_next n=%0d seq=%0d exp 1 rec seq 5",
               gseq.size(), (gseq.size() != 0) ? gseq[0] : 16'hffff);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] gseq[$];
    trc_ready = 0;
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c < 2) begin if_valid = 1; if_pc = 32'h700 + 32'(4 * c); end
      drive_wb();
      tick();
    end
    n_chk++;
    if (obs() !== expv() || mq.size() != 2) begin
      n_err++;
      $display("FAIL rmid_pre got=%h exp=%h", obs(), expv());
    end
    #2;
    rst = 1;
    model_reset();
    #1;
    n_chk++;
    if (obs() !== '0) begin
      n_err++;
      $display("FAIL rmid_async got=%h exp=0", obs());
    end
    idle();
    tick();
    rst = 0;
    trc_ready = 1;
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0) begin if_valid = 1; if_pc = 32'h800; end
      drive_wb();
      tick();
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL rmid_after c%0d got=%h exp=%h", c, obs(), expv());
      end
      if (trc_valid) gseq.push_back(trc_seq);
    end
    n_chk++;
    if (gseq.size() != 1 || gseq[0] !== 16'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_seq n=%0d ovf=%b exp 1 rec seq 0 ovf 0",
               gseq.size(), overflow);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if_valid  = ($urandom_range(0, 9) < 7);
      if_pc     = $urandom;
      if_instr  = $urandom;
      stall     = ($urandom_range(0, 9) < 2);
      flush     = ($urandom_range(0, 11) == 0);
      wb_we     = ($urandom_range(0, 1) == 1);
      wb_rd     = 5'($urandom);
      wb_data   = $urandom;
      trc_ready = ($urandom_range(0, 9) < 6);
      tick();
      n_chk++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL random c%0d got=%h exp=%h", c, obs(), expv());
      end
    end
  endtask

  initial begin
    idle();
    trc_ready = 1;
    test_reset();
    test_stream();
    test_addi();
    test_flush();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/retire_trace.md
RETIRE_TRACE -- requirements
Module: retire_trace

Interface
REQ-001 Parameter DEPTH, default 4, record FIFO entries (power of two, 2..16).
REQ-002 Parameter SEQ_W, default 16, retire sequence counter width.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 if_valid  input  1  fetched instruction enters IF/ID this cycle.
REQ-006 if_pc  input  32  PC of fetched instruction.
REQ-007 if_instr  input  32  fetched instruction word.
REQ-008 stall  input  1  freeze all shadow stages.
REQ-009 flush  input  1  kill IF/ID and ID/EX shadow entries (taken branch/jump).
REQ-010 wb_we  input  1  register-file write enable at WB.
REQ-011 wb_rd  input  5  WB destination register.
REQ-012 wb_data  input  32  WB write data.
REQ-013 trc_valid  output  1  record available.
REQ-014 trc_ready  input  1  consumer accepts record.
REQ-015 trc_pc, trc_instr, trc_data  output  32 each  retired PC, word, rd data.
REQ-016 trc_rd  output  5; trc_we  output  1  rd index and write flag.
REQ-017 trc_seq  output  SEQ_W  retire sequence number.
REQ-018 overflow  output  1  sticky, a record was dropped.

Function
REQ-019 Four shadow stages (IF/ID, ID/EX, EX/MEM, MEM/WB) each SHALL hold valid, pc, instr, matching the CPU 5-stage pipeline.
REQ-020 stall=0: stages advance one per cycle; IF/ID loads if_valid/if_pc/if_instr.
REQ-021 stall=1: all stages hold; no retire; flush ignored that cycle.
REQ-022 flush=1, stall=0: IF/ID and ID/EX valid cleared on that edge; EX/MEM, MEM/WB advance normally; new fetch not loaded.
REQ-023 Retire event: MEM/WB valid and stall=0; record = {pc, instr, wb_rd, wb_data, wb_we && wb_rd!=0, seq}.
REQ-024 Latency: record visible on trc_* one cycle after retire edge when FIFO empty.
REQ-025 Handshake: transfer on trc_valid && trc_ready; trc_* stable while valid && !ready.
REQ-026 seq increments by one per retire event including dropped ones; wraps 2^SEQ_W-1 -> 0.
REQ-027 FIFO full and retire with no same-cycle pop: record dropped, overflow set.
REQ-028 FIFO full, simultaneous retire and pop: both occur, no drop.
REQ-029 FIFO empty: trc_valid=0; no write-through bypass.

Reset
REQ-030 rst asserted: all stage valids, FIFO pointers, count, seq, overflow cleared immediately; trc_valid=0, trc_* data=0.
REQ-031 rst mid-operation discards in-flight and buffered records; first record after release has seq 0.

Configuration
REQ-032 Macro RETIRE_TRACE_STORE_EN: when defined, inputs mem_we(1), mem_addr(32), mem_wdata(32) sampled at EX/MEM stage, carried to MEM/WB, and outputs trc_st(1), trc_st_addr(32), trc_st_data(32) added to record.
REQ-033 Undefined: those ports and fields absent; record width unchanged otherwise.

Structure
REQ-034 Package retire_trace_pkg: typedef trace_rec_t (packed record), typedef stage_t, constant NOP_INSTR=32'h00000013.
REQ-035 Sub-module trace_fifo (DEPTH, width of trace_rec_t, push/pop/full/empty) instantiated once.

Verification
REQ-036 Reset, then 6 instrs at PC 0x0..0x14, trc_ready=1 -> records seq 0..5, first trc_valid 5 cycles after first if_valid, PCs in order.
REQ-037 ADDI x5,x0,7 (0x00700293) retired, wb_data=7 -> trc_rd=5, trc_we=1, trc_data=0x7; NOP -> trc_we=0.
REQ-038 flush pulse with PCs 0x8,0xC in IF/ID, ID/EX -> neither retires; seq contiguous, no gap.
REQ-039 stall held 3 cycles mid-stream -> no duplicate or lost records, order preserved.
REQ-040 trc_ready=0, retire DEPTH+1 instrs -> DEPTH records held seq 0..3, overflow=1, next accepted record seq 5.
REQ-041 rst pulsed with 2 records buffered -> trc_valid=0 asynchronously; next record seq 0, overflow=0.
